// File: rtl/life_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : life_pkg
//  Purpose  : Shared types and constants for the Life grid controller.
//             - state_t  : controller state encoding
//             - CELL_LAT : cycles from a sampled write/enb to the cell output
//             - cell_idx : raster index of a cell (row*cols + col)
//  Revision : 1.0  initial release
// ============================================================================
package life_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    LOAD    = 3'd2,
    STEP    = 3'd3,
    SETTLE1 = 3'd4,
    SETTLE2 = 3'd5
  } state_t;

  // Latency of the cell array: a write or enb sampled at one edge is seen on
  // the alive outputs two cycles later.
  localparam int CELL_LAT = 2;

  function automatic int cell_idx(input int row, input int col, input int cols);
    return row * cols + col;
  endfunction

endpackage
`default_nettype wire

// File: rtl/life_tick_div.sv
`default_nettype none
// ============================================================================
//  Module   : life_tick_div
//  Purpose  : Generation tick divider for run mode. Counts 0..TICK_DIV-1
//             while run is high and parks at TICK_DIV-1 until the controller
//             consumes the tick. Held at zero while run is low.
//  Ports    : clk      - system clock
//             reset    - synchronous, active-low reset
//             run      - free-running mode enable
//             consume  - controller accepted the pending tick
//             expired  - a tick is pending
//  Revision : 1.0  initial release
// ============================================================================
module life_tick_div #(
  parameter int TICK_DIV = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic consume,
  output logic expired
);

  localparam int               c_cnt_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TICK_DIV - 1);

  logic [c_cnt_w-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
    end else if (!run || consume) begin
      r_count <= '0;
    end else if (r_count != c_last) begin
      r_count <= r_count + c_cnt_w'(1);
    end
  end

  assign expired = run && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/life_grid_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : life_grid_ctrl
//  Purpose  : Drives the write/val/enb side of a ROWS x COLS Life cell array.
//             Loads a raster-order pattern over a valid/ready stream, clears
//             the grid in one cycle, and issues single-cycle generation
//             pulses (tick-driven in run mode, or on a manual step).
//  Ports    : clk, reset         - clock, synchronous active-low reset
//             clear, load_start  - grid clear / pattern load requests
//             pix_valid/pix_data - pattern stream in, pix_ready handshake out
//             run, step          - free-running level / single-step pulse
//             write, val         - per-cell write enables, broadcast value
//             enb                - generation enable pulse
//             busy, load_done    - status
//             gen_count          - generations issued since clear/load/reset
//  Revision : 1.0  initial release
// ============================================================================
module life_grid_ctrl
  import life_pkg::*;
#(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int TICK_DIV = 1000000,
  parameter int GEN_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 load_start,
  input  logic                 pix_valid,
  input  logic                 pix_data,
  output logic                 pix_ready,
  input  logic                 run,
  input  logic                 step,
  output logic [ROWS*COLS-1:0] write,
  output logic                 val,
  output logic                 enb,
  output logic                 busy,
  output logic                 load_done,
  output logic [GEN_W-1:0]     gen_count
);

  localparam int                 c_cells    = ROWS * COLS;
  localparam int                 c_idx_w    = (c_cells > 1) ? $clog2(c_cells) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_cells - 1);

  state_t               r_state;
  logic [c_idx_w-1:0]   r_index;
  logic [c_cells-1:0]   r_write;
  logic                 r_val;
  logic                 r_enb;
  logic                 r_busy;
  logic                 r_load_done;
  logic                 r_load_pend;   // settle sequence belongs to a load
  logic [GEN_W-1:0]     r_gen;

  logic                 w_tick;
  logic                 w_tick_take;
  logic [c_cells-1:0]   w_onehot;

  // A tick is only consumed when IDLE actually turns it into a step; a
  // higher-priority clear/load leaves it pending.
  assign w_tick_take = (r_state == IDLE) && !clear && !load_start && run && w_tick;

  life_tick_div #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_div (
    .clk     (clk),
    .reset   (reset),
    .run     (run),
    .consume (w_tick_take),
    .expired (w_tick)
  );

  for (genvar gi = 0; gi < c_cells; gi++) begin : g_onehot
    assign w_onehot[gi] = (r_index == c_idx_w'(gi));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_index     <= '0;
      r_write     <= '0;
      r_val       <= 1'b0;
      r_enb       <= 1'b0;
      r_busy      <= 1'b0;
      r_load_done <= 1'b0;
      r_load_pend <= 1'b0;
      r_gen       <= '0;
    end else begin
      // Pulsed outputs default low every cycle.
      r_write     <= '0;
      r_enb       <= 1'b0;
      r_load_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (clear) begin
            r_state <= CLEAR;
            r_write <= '1;
            r_val   <= 1'b0;
            r_gen   <= '0;
            r_busy  <= 1'b1;
          end else if (load_start) begin
            r_state <= LOAD;
            r_index <= '0;
            r_gen   <= '0;
            r_busy  <= 1'b1;
          end else if ((run && w_tick) || (!run && step)) begin
            r_state <= STEP;
            r_enb   <= 1'b1;
            r_gen   <= r_gen + GEN_W'(1);
            r_busy  <= 1'b1;
          end
        end
        CLEAR: r_state <= SETTLE1;
        LOAD: begin
          // pix_ready is high throughout LOAD, so valid alone marks a transfer.
          if (pix_valid) begin
            r_write <= w_onehot;
            r_val   <= pix_data;
            r_index <= r_index + c_idx_w'(1);
            if (r_index == c_last_idx) begin
              r_state     <= SETTLE1;
              r_load_pend <= 1'b1;
            end
          end
        end
        STEP:    r_state <= SETTLE1;
        SETTLE1: r_state <= SETTLE2;
        SETTLE2: begin
          r_state     <= IDLE;
          r_busy      <= 1'b0;
          r_load_done <= r_load_pend;
          r_load_pend <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign pix_ready = (r_state == LOAD);
  assign write     = r_write;
  assign val       = r_val;
  assign enb       = r_enb;
  assign busy      = r_busy;
  assign load_done = r_load_done;
  assign gen_count = r_gen;

endmodule
`default_nettype wire
